// File: rtl/vector_alu_pkg.sv
// vector_alu_pkg: shared op/state encodings and counter sizing for the vector ALU
package vector_alu_pkg;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_DIV  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_ADD2 = 3'b111
  } op_e;
  typedef enum logic [1:0] {IDLE, DIV, HOLD} state_e;
  localparam int W_DEF = 32;
  localparam int CNT_W = $clog2(W_DEF);
  function automatic int cnt_width(input int w);
    return w > 2 ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/valu_lane.sv
// valu_lane: one element lane; single-cycle op mux, restoring divider step and result flags
module valu_lane
  import vector_alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic         last,
  input  op_e          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic         zero,
  output logic         div0
);
  logic [W-1:0] dvd, dvs, rem, alu, rem_n, quo_n;
  logic [W:0] rem_sh;
  logic ge;
  always_comb begin
    case (op)
      OP_SUB:  alu = a - b;
      OP_MUL:  alu = a * b;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_XOR:  alu = a ^ b;
      default: alu = a + b;
    endcase
  end
  // quotient bits shift into the dividend register as its MSBs are consumed
  assign rem_sh = {rem, dvd[W-1]};
  assign ge     = rem_sh >= {1'b0, dvs};
  assign rem_n  = ge ? rem_sh[W-1:0] - dvs : rem_sh[W-1:0];
  assign quo_n  = {dvd[W-2:0], ge};
  always_ff @(posedge clk) begin
    if (rst) begin
      c    <= '0;
      zero <= 1'b0;
      div0 <= 1'b0;
      dvd  <= '0;
      dvs  <= '0;
      rem  <= '0;
    end else if (load) begin
      if (op == OP_DIV) begin
        dvd <= a;
        dvs <= b;
        rem <= '0;
      end else begin
        c    <= alu;
        zero <= alu == '0;
        div0 <= 1'b0;
      end
    end else if (step) begin
      rem <= rem_n;
      dvd <= quo_n;
      if (last) begin
        c    <= quo_n;
        zero <= quo_n == '0;
        div0 <= dvs == '0;
      end
    end
  end
endmodule

// File: rtl/vector_alu.sv
// vector_alu: multi-lane vector ALU with shared handshake FSM and iterative divide sequencing
module vector_alu
  import vector_alu_pkg::*;
#(
  parameter int LANES = 6,
  parameter int W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [LANES*W-1:0] va,
  input  logic [LANES*W-1:0] vb,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] vc,
  output logic [LANES-1:0]   zero_mask,
  output logic               flagZ,
  output logic [LANES-1:0]   div0_mask
);
  localparam int CW = cnt_width(W);
  state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic accept, is_div, last, step;
  assign in_ready  = state == IDLE || (state == HOLD && out_ready);
  assign out_valid = state == HOLD;
  assign accept    = in_valid && in_ready;
  assign is_div    = op == OP_DIV;
  assign last      = cnt == '0;
  assign step      = state == DIV;
  assign flagZ     = &zero_mask;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (accept) begin
      state_n = is_div ? DIV : HOLD;
      cnt_n   = is_div ? CW'(W - 1) : cnt;
    end else if (state == DIV) begin
      state_n = last ? HOLD : DIV;
      cnt_n   = last ? cnt : cnt - 1'b1;
    end else if (state == HOLD && out_ready) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    valu_lane #(.W(W)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (accept),
      .step (step),
      .last (last),
      .op   (op_e'(op)),
      .a    (va[i*W +: W]),
      .b    (vb[i*W +: W]),
      .c    (vc[i*W +: W]),
      .zero (zero_mask[i]),
      .div0 (div0_mask[i])
    );
  end
endmodule

// File: tb/tb_vector_alu.sv
// tb_vector_alu: scoreboard bench; expectations queued at accept, checked when results hand off
module tb_vector_alu;
  localparam int L = 6;
  localparam int W = 32;
  typedef struct {
    logic [L*W-1:0] vc;
    logic [L-1:0]   z;
    logic           fz;
    logic [L-1:0]   d0;
  } exp_t;
  logic clk, rst, in_valid, in_ready, out_valid, out_ready, flagZ;
  logic [2:0] op;
  logic [L*W-1:0] va, vb, vc;
  logic [L-1:0] zero_mask, div0_mask;
  exp_t q[$];
  exp_t e;
  int n_chk, n_fail;
  vector_alu #(.LANES(L), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .va(va), .vb(vb), .out_valid(out_valid), .out_ready(out_ready), .vc(vc),
    .zero_mask(zero_mask), .flagZ(flagZ), .div0_mask(div0_mask)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [L*W-1:0] rep(input logic [W-1:0] x);
    return {L{x}};
  endfunction
  function automatic exp_t model(input logic [2:0] o, input logic [L*W-1:0] a, input logic [L*W-1:0] b);
    exp_t r;
    logic [W-1:0] x, y, z;
    r.vc = '0;
    r.z  = '0;
    r.d0 = '0;
    for (int i = 0; i < L; i++) begin
      x = a[i*W +: W];
      y = b[i*W +: W];
      case (o)
        3'd1:    z = x - y;
        3'd2:    z = x * y;
        3'd3:    z = (y == 0) ? '1 : x / y;
        3'd4:    z = x & y;
        3'd5:    z = x | y;
        3'd6:    z = x ^ y;
        default: z = x + y;
      endcase
      r.vc[i*W +: W] = z;
      r.z[i]  = z == 0;
      r.d0[i] = o == 3'd3 && y == 0;
    end
    r.fz = &r.z;
    return r;
  endfunction
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", out_valid, 0);
      else begin
        e = q.pop_front();
        chk("sb_vc", vc, e.vc);
        chk("sb_zero_mask", zero_mask, e.z);
        chk("sb_flagZ", flagZ, e.fz);
        chk("sb_div0_mask", div0_mask, e.d0);
      end
    end
  end
  task automatic send(input logic [2:0] o, input logic [L*W-1:0] a, input logic [L*W-1:0] b);
    logic acc;
    acc = 0;
    op = o;
    va = a;
    vb = b;
    in_valid = 1;
    for (int i = 0; i < 200 && !acc; i++) begin
      #1 acc = in_ready;
      @(posedge clk);
    end
    if (acc) q.push_back(model(o, a, b));
    else chk("accept_timeout", acc, 1);
    #1 in_valid = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [L*W-1:0] a, b, vc_s;
    logic [L-1:0] zm_s, d0_s;
    int lat;
    logic busy;
    n_chk = 0;
    n_fail = 0;
    rst = 1;
    in_valid = 0;
    out_ready = 1;
    op = 0;
    va = '0;
    vb = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_vc", vc, 0);
    chk("rst_flags", {zero_mask, flagZ, div0_mask}, 0);
    // add with wrap in lane 0
    a = rep(32'd5);
    b = rep(32'd3);
    a[W-1:0] = 32'hFFFF_FFFF;
    b[W-1:0] = 32'd1;
    send(3'b000, a, b);
    chk("add_lat", out_valid, 1);
    chk("add_zero_mask", zero_mask, 6'b000001);
    chk("add_flagZ", flagZ, 0);
    send(3'b001, rep(32'd7), rep(32'd7));
    chk("sub_flagZ", flagZ, 1);
    send(3'b010, rep(32'h10000), rep(32'h10000));
    chk("mul_wrap_zero", zero_mask, 6'b111111);
    // divide, including a divide-by-zero lane
    a = rep(32'hFFFF_FFFF);
    b = rep(32'd1);
    a[W-1:0] = 32'd100;
    b[W-1:0] = 32'd7;
    a[2*W-1:W] = 32'd7;
    b[2*W-1:W] = 32'd0;
    send(3'b011, a, b);
    lat = 1;
    busy = 1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy = 0;
      @(posedge clk);
      #1 lat++;
    end
    chk("div_lat", lat, W + 1);
    chk("div_busy", busy, 1);
    chk("div_lane0", vc[W-1:0], 14);
    chk("div0_mask", div0_mask, 6'b000010);
    // backpressure
    @(posedge clk);
    #1 out_ready = 0;
    send(3'b000, rep(32'd1), rep(32'd2));
    vc_s = vc;
    zm_s = zero_mask;
    d0_s = div0_mask;
    for (int i = 0; i < 5; i++) begin
      chk("bp_vc", vc, vc_s);
      chk("bp_flags", {zero_mask, div0_mask}, {zm_s, d0_s});
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1;
    send(3'b110, rep(32'hF0F0_F0F0), rep(32'hFFFF_FFFF));
    chk("bp_xor", vc, rep(32'h0F0F_0F0F));
    // back-to-back single-cycle ops
    for (int i = 0; i < 4; i++) begin
      send(3'b000, rep($urandom), rep($urandom));
      chk("b2b_valid", out_valid, 1);
    end
    // every encoding with an equal lane and a zero lane
    for (int o = 0; o < 8; o++) begin
      for (int i = 0; i < L; i++) begin
        a[i*W +: W] = $urandom;
        b[i*W +: W] = $urandom_range(32'hFFFF, 1);
      end
      b[2*W +: W] = a[2*W +: W];
      b[3*W +: W] = 0;
      send(3'(o), a, b);
    end
    repeat (40) @(posedge clk);
    // reset in the middle of a divide
    #1;
    send(3'b011, rep(32'd1000), rep(32'd3));
    repeat (9) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    q.delete();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_vc", vc, 0);
    chk("mid_rst_flags", {zero_mask, flagZ, div0_mask}, 0);
    repeat (50) @(posedge clk);
    #1 chk("post_rst_idle", out_valid, 0);
    chk("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
